id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Stage 2 (decode) of the RV32I pipeline. Produces the decoded operand and field bundle consumed by the execute stage: rs1/rs2 data, immediate, rd, opcode, funct3, funct7.
- Holds the 32x32 integer register file and accepts the write-back port.
- Registers its outputs in the ID/EX pipeline register, with a valid/ready handshake on both sides and a flush input.

Parameters:
- XLEN, 32, datapath width
- NREGS, 32, number of architectural registers (x0 hardwired zero)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  fetch presents an instruction
- if_ready  out  1  decode can accept an instruction this cycle
- if_instr  in  32  instruction word
- if_pc  in  32  instruction PC
- flush  in  1  kill the held instruction and the incoming instruction
- wb_en  in  1  register write enable
- wb_rd  in  5  write destination
- wb_data  in  32  write data
- ex_valid  out  1  ID/EX bundle valid
- ex_ready  in  1  execute consumes the bundle
- ex_rs1_data  out  32  rs1 operand
- ex_rs2_data  out  32  rs2 operand
- ex_imm  out  32  sign-extended immediate
- ex_rd  out  5  destination (0 if none)
- ex_opcode  out  7  instr[6:0]
- ex_funct3  out  3  instr[14:12]
- ex_funct7  out  7  instr[31:25]
- ex_pc  out  32  PC of the bundle
- ex_illegal  out  1  opcode not in the RV32I base set

Behaviour:
- Reset (rst_n low, asynchronous): all ex_* outputs are 0, ex_valid=0, and all registers x0..x31 are cleared to 0. if_ready=1 after reset.
- Handshake:
  - if_ready = !ex_valid || ex_ready (combinational).
  - The bundle is captured on the rising edge when if_valid && if_ready && !flush.
  - Latency is 1 cycle: ex_valid rises the cycle after capture.
- Stall: while ex_valid && !ex_ready, all ex_* outputs hold bit-stable.
- Valid update: if ex_ready && ex_valid and there is no new capture, ex_valid goes 0 on the next edge. Data fields may keep their stale values.
- Flush:
  - Has priority over capture. On the next edge ex_valid=0, and the incoming instruction is dropped.
  - if_ready may be 1 during the flush cycle, but no capture occurs.
- Register file:
  - Write at the rising edge when wb_en && wb_rd!=0. Writes to x0 are ignored; x0 always reads 0.
  - Reads are combinational from instr[19:15] and instr[24:20].
  - Write-through bypass: if wb_en && wb_rd==rsN && rsN!=0 in the capture cycle, the captured operand is wb_data.
  - Write-back is independent of stall and flush.
  - A held (stalled) bundle is not refreshed by later writes. Operand forwarding for that case belongs to the forwarding unit.
- Immediate generation by opcode:
  - I-type (0010011, 0000011, 1100111): sext(instr[31:20]).
  - S-type (0100011): sext({instr[31:25], instr[11:7]}).
  - B-type (1100011): sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}.
  - J-type (1101111): sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - R-type (0110011) and others: 0.
- rd: ex_rd = instr[11:7] except for S-type, B-type, and illegal opcodes, which force ex_rd=0.
- ex_opcode, ex_funct3 and ex_funct7 are always the raw instruction fields.
- Illegal instructions: any opcode outside the 9 base opcodes plus 0001111 (FENCE) and 1110011 (SYSTEM) sets ex_illegal=1. The bundle is still valid and still flows.
- Simultaneous events:
  - Capture with ex_ready on the same edge gives a back-to-back throughput of 1 instruction per cycle.
  - Flush together with wb_en: the write is still performed.

Decomposition:
- rv32_pkg holds the opcode localparams (OP_IMM, OP, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, FENCE, SYSTEM) and an imm_fmt_t enum {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J}, shared with the execute stage.
- Sub-module regfile_2r1w (2 async read ports, 1 sync write port, x0 zero, reset clear) is instantiated once. Bypass logic lives in id_stage.

Test Plan:
- Reset mid-run: assert rst_n=0 while ex_valid=1 -> ex_valid=0 immediately and all outputs 0. After release, ADD x3,x2,x2 (0x002101B3) gives rs1_data=rs2_data=0.
- ADDI x1,x0,5 (0x00500093) with ex_ready=1 -> next cycle ex_valid=1, opcode=0x13, rd=1, funct3=0, imm=0x00000005, rs1_data=0, ex_illegal=0.
- Bypass: wb_en=1, wb_rd=2, wb_data=0xDEADBEEF in the same cycle as 0x002101B3 is presented -> ex_rs1_data=ex_rs2_data=0xDEADBEEF, ex_rd=3.
- Write to x0: wb_rd=0, wb_data=0x12345678, then ADD reading x0 -> rs1_data=0.
- BEQ x0,x0,-4 (0xFE000EE3) -> imm=0xFFFFFFFC, rd=0, funct3=0. LUI x5,0xABCDE (0xABCDE2B7) -> imm=0xABCDE000, rd=5.
- Stall then flush: hold ex_ready=0 for 3 cycles -> if_ready=0 and outputs stable. Pulse flush -> ex_valid=0 next cycle. Opcode 0x7F -> ex_illegal=1, rd=0.

Source files
------------

// File: rtl/rv32_pkg.sv
// -----------------------------------------------------------------------------
// rv32_pkg
// Shared RV32I decode definitions used by the decode and execute stages:
//   - base opcode constants
//   - imm_fmt_t : immediate encoding format of an instruction
//   - imm_fmt() : opcode -> immediate format
//   - is_legal(): opcode belongs to the RV32I base set (incl. FENCE/SYSTEM)
//   - gen_imm() : sign-extended immediate for a full instruction word
// -----------------------------------------------------------------------------
package rv32_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] FENCE  = 7'b0001111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_t;

  // FENCE/SYSTEM and unknown opcodes fall into FMT_R, which yields a zero
  // immediate.
  function automatic imm_fmt_t imm_fmt(input logic [6:0] op);
    imm_fmt_t fmt;
    case (op)
      OP_IMM, LOAD, JALR: fmt = FMT_I;
      STORE:              fmt = FMT_S;
      BRANCH:             fmt = FMT_B;
      LUI, AUIPC:         fmt = FMT_U;
      JAL:                fmt = FMT_J;
      default:            fmt = FMT_R;
    endcase
    return fmt;
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    logic ok;
    case (op)
      OP_IMM, OP, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, FENCE, SYSTEM: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] gen_imm(input logic [31:0] instr);
    logic [31:0] imm;
    case (imm_fmt(instr[6:0]))
      FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'b0};
      FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'b0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// -----------------------------------------------------------------------------
// id_stage_if
// Bus bundle around the decode stage:
//   fetch side   : if_valid, if_ready, if_instr, if_pc, flush
//   write-back   : wb_en, wb_rd, wb_data
//   execute side : ex_valid, ex_ready, ex_* decoded fields
// Modports: master = environment (fetch/WB/execute), slave = id_stage.
// -----------------------------------------------------------------------------
interface id_stage_if #(
  parameter int XLEN = 32
);
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [31:0]     if_pc;
  logic            flush;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [31:0]     ex_imm;
  logic [4:0]      ex_rd;
  logic [6:0]      ex_opcode;
  logic [2:0]      ex_funct3;
  logic [6:0]      ex_funct7;
  logic [31:0]     ex_pc;
  logic            ex_illegal;

  modport master (
    output if_valid, if_instr, if_pc, flush, wb_en, wb_rd, wb_data, ex_ready,
    input  if_ready, ex_valid, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd,
           ex_opcode, ex_funct3, ex_funct7, ex_pc, ex_illegal
  );

  modport slave (
    input  if_valid, if_instr, if_pc, flush, wb_en, wb_rd, wb_data, ex_ready,
    output if_ready, ex_valid, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd,
           ex_opcode, ex_funct3, ex_funct7, ex_pc, ex_illegal
  );
endinterface

// File: rtl/id_stage_regfile.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
// Integer register file: 2 combinational read ports, 1 synchronous write port.
// x0 is not stored and always reads 0; writes to x0 are dropped.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset (clears all regs)
//   i_we/i_waddr/i_wdata: write port
//   i_raddr1/o_rdata1   : read port 1
//   i_raddr2/o_rdata2   : read port 2
// -----------------------------------------------------------------------------
module regfile_2r1w #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [AW-1:0]   i_raddr1,
  input  logic [AW-1:0]   i_raddr2,
  output logic [XLEN-1:0] o_rdata1,
  output logic [XLEN-1:0] o_rdata2
);

  // Entry 0 is intentionally absent; the read muxes supply the zero.
  logic [XLEN-1:0] r_regs [1:NREGS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_regs[i_raddr2];

endmodule

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage
// RV32I decode stage. Reads operands from the register file (with write-back
// bypass), generates the immediate and destination, flags illegal opcodes and
// registers the result in the ID/EX pipeline register.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : id_stage_if.slave (fetch handshake, flush, write-back port,
//           ID/EX handshake and decoded bundle)
// -----------------------------------------------------------------------------
module id_stage
  import rv32_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  id_stage_if.slave    bus
);

  logic [4:0]      w_rs1_addr;
  logic [4:0]      w_rs2_addr;
  logic [XLEN-1:0] w_rf_rs1;
  logic [XLEN-1:0] w_rf_rs2;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;
  logic [6:0]      w_opcode;
  logic            w_legal;
  imm_fmt_t        w_fmt;
  logic [4:0]      w_rd;
  logic            w_if_ready;
  logic            w_capture;

  logic            r_ex_valid;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [31:0]     r_imm;
  logic [4:0]      r_rd;
  logic [6:0]      r_opcode;
  logic [2:0]      r_funct3;
  logic [6:0]      r_funct7;
  logic [31:0]     r_pc;
  logic            r_illegal;

  assign w_rs1_addr = bus.if_instr[19:15];
  assign w_rs2_addr = bus.if_instr[24:20];

  regfile_2r1w #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (bus.wb_en),
    .i_waddr  (bus.wb_rd),
    .i_wdata  (bus.wb_data),
    .i_raddr1 (w_rs1_addr),
    .i_raddr2 (w_rs2_addr),
    .o_rdata1 (w_rf_rs1),
    .o_rdata2 (w_rf_rs2)
  );

  // Write-through: a write landing on the same edge as the capture must be
  // visible in the captured operand, since the array only updates at that edge.
  assign w_rs1_data = (bus.wb_en && (bus.wb_rd == w_rs1_addr) && (w_rs1_addr != 5'd0))
                      ? bus.wb_data : w_rf_rs1;
  assign w_rs2_data = (bus.wb_en && (bus.wb_rd == w_rs2_addr) && (w_rs2_addr != 5'd0))
                      ? bus.wb_data : w_rf_rs2;

  assign w_opcode = bus.if_instr[6:0];
  assign w_legal  = is_legal(w_opcode);
  assign w_fmt    = imm_fmt(w_opcode);

  // Stores, branches and illegal opcodes write no register.
  assign w_rd = (!w_legal || (w_fmt == FMT_S) || (w_fmt == FMT_B))
                ? 5'd0 : bus.if_instr[11:7];

  assign w_if_ready = !r_ex_valid || bus.ex_ready;
  assign w_capture  = bus.if_valid && w_if_ready && !bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid <= 1'b0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rd       <= '0;
      r_opcode   <= '0;
      r_funct3   <= '0;
      r_funct7   <= '0;
      r_pc       <= '0;
      r_illegal  <= 1'b0;
    end else if (bus.flush) begin
      r_ex_valid <= 1'b0;
    end else if (w_capture) begin
      r_ex_valid <= 1'b1;
      r_rs1_data <= w_rs1_data;
      r_rs2_data <= w_rs2_data;
      r_imm      <= gen_imm(bus.if_instr);
      r_rd       <= w_rd;
      r_opcode   <= w_opcode;
      r_funct3   <= bus.if_instr[14:12];
      r_funct7   <= bus.if_instr[31:25];
      r_pc       <= bus.if_pc;
      r_illegal  <= !w_legal;
    end else if (bus.ex_ready) begin
      // Consumed with nothing new behind it; data fields keep stale values.
      r_ex_valid <= 1'b0;
    end
  end

  assign bus.if_ready    = w_if_ready;
  assign bus.ex_valid    = r_ex_valid;
  assign bus.ex_rs1_data = r_rs1_data;
  assign bus.ex_rs2_data = r_rs2_data;
  assign bus.ex_imm      = r_imm;
  assign bus.ex_rd       = r_rd;
  assign bus.ex_opcode   = r_opcode;
  assign bus.ex_funct3   = r_funct3;
  assign bus.ex_funct7   = r_funct7;
  assign bus.ex_pc       = r_pc;
  assign bus.ex_illegal  = r_illegal;

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage
// Scoreboard bench for id_stage: the driver pushes the hand-computed bundle
// for each issued instruction; a monitor pops and compares whenever the stage
// hands a bundle to execute (ex_valid && ex_ready). Stall, flush and reset
// behaviour are checked directly.
// -----------------------------------------------------------------------------
module tb_id_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_stage_if #(.XLEN(32)) ifc ();

  id_stage #(.XLEN(32), .NREGS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: a bundle is handed over at the next edge when valid && ready.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ifc.ex_valid === 1'b1 && ifc.ex_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_bundle: got pc %08h expected no bundle", ifc.ex_pc);
      end else begin
        mon_e = sb.pop_front();
        $display("txn instr=%08h pc=%08h rs1=%08h rs2=%08h imm=%08h rd=%0d ill=%0b",
                 mon_e.instr, ifc.ex_pc, ifc.ex_rs1_data, ifc.ex_rs2_data,
                 ifc.ex_imm, ifc.ex_rd, ifc.ex_illegal);
        chk("pc",      ifc.ex_pc,       mon_e.pc);
        chk("rs1",     ifc.ex_rs1_data, mon_e.rs1);
        chk("rs2",     ifc.ex_rs2_data, mon_e.rs2);
        chk("imm",     ifc.ex_imm,      mon_e.imm);
        chk("rd",      32'(ifc.ex_rd),  32'(mon_e.rd));
        chk("opcode",  32'(ifc.ex_opcode), 32'(mon_e.instr[6:0]));
        chk("funct3",  32'(ifc.ex_funct3), 32'(mon_e.instr[14:12]));
        chk("funct7",  32'(ifc.ex_funct7), 32'(mon_e.instr[31:25]));
        chk("illegal", 32'(ifc.ex_illegal), 32'(mon_e.ill));
      end
    end
  end

  // Issue one instruction (capture assumed: if_ready=1, no flush) with an
  // optional write-back in the same cycle.
  task automatic send(input logic [31:0] instr, input logic [31:0] rs1,
                      input logic [31:0] rs2, input logic [31:0] imm,
                      input logic [4:0] rd, input logic ill,
                      input logic wen, input logic [4:0] wrd, input logic [31:0] wdat);
    exp_t e;
    e.instr = instr; e.pc = pc_ctr; e.rs1 = rs1; e.rs2 = rs2;
    e.imm = imm; e.rd = rd; e.ill = ill;
    sb.push_back(e);
    ifc.if_valid = 1'b1;
    ifc.if_instr = instr;
    ifc.if_pc    = pc_ctr;
    ifc.wb_en    = wen;
    ifc.wb_rd    = wrd;
    ifc.wb_data  = wdat;
    @(posedge clk); #1;
    ifc.if_valid = 1'b0;
    ifc.wb_en    = 1'b0;
    pc_ctr       = pc_ctr + 32'd4;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within 200000");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n        = 1'b0;
    ifc.if_valid = 1'b0;
    ifc.if_instr = '0;
    ifc.if_pc    = '0;
    ifc.flush    = 1'b0;
    ifc.wb_en    = 1'b0;
    ifc.wb_rd    = '0;
    ifc.wb_data  = '0;
    ifc.ex_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", 32'(ifc.ex_valid), 32'd0);
    chk("rst_if_ready", 32'(ifc.if_ready), 32'd1);
    chk("rst_imm",      ifc.ex_imm,        32'd0);
    chk("rst_pc",       ifc.ex_pc,         32'd0);
    rst_n = 1'b1;
    idle();

    // Back-to-back stream, ex_ready held high.
    send(32'h00500093, 32'h0, 32'h0, 32'h5, 5'd1, 1'b0, 1'b0, 5'd0, 32'h0);             // ADDI x1,x0,5
    send(32'h002101B3, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 5'd3, 1'b0,
         1'b1, 5'd2, 32'hDEADBEEF);                                                   // ADD x3,x2,x2 + bypass
    send(32'h002101B3, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 5'd3, 1'b0, 1'b0, 5'd0, 32'h0); // from regfile
    send(32'hFFF10313, 32'hDEADBEEF, 32'h0, 32'hFFFFFFFF, 5'd6, 1'b0, 1'b0, 5'd0, 32'h0); // ADDI x6,x2,-1
    send(32'h00202623, 32'h0, 32'hDEADBEEF, 32'h0000000C, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0); // SW x2,12(x0)
    // Write to x0 while idle, then again alongside a read of x0.
    ifc.wb_en = 1'b1; ifc.wb_rd = 5'd0; ifc.wb_data = 32'h12345678;
    idle();
    ifc.wb_en = 1'b0;
    send(32'h00000233, 32'h0, 32'h0, 32'h0, 5'd4, 1'b0, 1'b1, 5'd0, 32'h12345678);       // ADD x4,x0,x0
    idle();

    // Stall: one bundle held for 3 cycles while fetch offers another.
    ifc.ex_ready = 1'b0;
    ifc.if_valid = 1'b1; ifc.if_instr = 32'h00500093; ifc.if_pc = 32'h0000_2000;
    idle();
    ifc.if_instr = 32'h00000FFF; ifc.if_pc = 32'h0000_2004;
    for (int k = 0; k < 3; k++) begin
      chk("stall_if_ready", 32'(ifc.if_ready), 32'd0);
      chk("stall_valid",    32'(ifc.ex_valid), 32'd1);
      chk("stall_imm",      ifc.ex_imm,        32'd5);
      chk("stall_rd",       32'(ifc.ex_rd),    32'd1);
      chk("stall_pc",       ifc.ex_pc,         32'h0000_2000);
      idle();
    end
    // Flush the held bundle together with a write to x7.
    ifc.flush = 1'b1; ifc.wb_en = 1'b1; ifc.wb_rd = 5'd7; ifc.wb_data = 32'h000055AA;
    idle();
    ifc.flush = 1'b0; ifc.wb_en = 1'b0; ifc.if_valid = 1'b0;
    chk("flush_valid", 32'(ifc.ex_valid), 32'd0);
    // Flush with if_ready=1: the incoming instruction must be dropped.
    ifc.ex_ready = 1'b1;
    ifc.if_valid = 1'b1; ifc.if_instr = 32'h00500093; ifc.flush = 1'b1;
    #1;
    chk("flush_if_ready", 32'(ifc.if_ready), 32'd1);
    idle();
    ifc.flush = 1'b0; ifc.if_valid = 1'b0;
    chk("flush_drop_valid", 32'(ifc.ex_valid), 32'd0);

    send(32'h00038433, 32'h000055AA, 32'h0, 32'h0, 5'd8, 1'b0, 1'b0, 5'd0, 32'h0);       // ADD x8,x7,x0
    send(32'h00000FFF, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0);              // illegal 0x7F
    send(32'hFE000EE3, 32'h0, 32'h0, 32'hFFFFFFFC, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0);       // BEQ x0,x0,-4
    send(32'hABCDE2B7, 32'h0, 32'h0, 32'hABCDE000, 5'd5, 1'b0, 1'b0, 5'd0, 32'h0);       // LUI x5,0xABCDE
    send(32'h010000EF, 32'h0, 32'h0, 32'h00000010, 5'd1, 1'b0, 1'b0, 5'd0, 32'h0);       // JAL x1,16
    idle();

    // Reset mid-run with a bundle held valid.
    ifc.ex_ready = 1'b0;
    ifc.if_valid = 1'b1; ifc.if_instr = 32'h00500093; ifc.if_pc = 32'h0000_3000;
    idle();
    ifc.if_valid = 1'b0;
    chk("pre_rst_valid", 32'(ifc.ex_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid",  32'(ifc.ex_valid),  32'd0);
    chk("async_rst_imm",    ifc.ex_imm,         32'd0);
    chk("async_rst_rd",     32'(ifc.ex_rd),     32'd0);
    chk("async_rst_opcode", 32'(ifc.ex_opcode), 32'd0);
    chk("async_rst_pc",     ifc.ex_pc,          32'd0);
    chk("async_rst_if_rdy", 32'(ifc.if_ready),  32'd1);
    idle();
    rst_n = 1'b1;
    ifc.ex_ready = 1'b1;
    idle();
    send(32'h002101B3, 32'h0, 32'h0, 32'h0, 5'd3, 1'b0, 1'b0, 5'd0, 32'h0);              // x2 cleared

    for (int i = 0; i < 10 && sb.size() != 0; i++) begin
      @(posedge clk);
    end
    @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending bundles expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
